// File: rtl/lc3b_data_mem_responder.sv
// Fixed-latency word RAM that answers the LC-3b pipeline data-memory requests.
// Optional build macro LC3B_MEM_ALIGN_CHECK_EN flags misaligned full-word accesses.
module lc3b_data_mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int IDX_BITS = ADDR_BITS - 1;
  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;
  logic [3:0] count, count_nx;

  logic [IDX_BITS-1:0] idx_q;
  logic [15:0] wdata_q;
  logic [1:0] be_q;
  logic rd_q, wr_q, bad_q;

  logic [15:0] ram [DEPTH];

  logic req, misalign, bad_in, enter_resp;
  logic [IDX_BITS-1:0] acc_idx;
  logic [15:0] acc_wdata;
  logic [1:0] acc_be;
  logic acc_rd, acc_wr, acc_bad;

  assign req = mem_read | mem_write;

`ifdef LC3B_MEM_ALIGN_CHECK_EN
  assign misalign = (mem_byte_enable == 2'b11) && mem_address[0];
`else
  assign misalign = 1'b0;
`endif

  assign bad_in = (mem_read & mem_write) | misalign;

  // With LATENCY=1 the access completes straight from IDLE, before anything is latched.
  always_comb begin
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    acc_rd    = rd_q;
    acc_wr    = wr_q;
    acc_bad   = bad_q;
    if (state == IDLE) begin
      acc_idx   = mem_address[ADDR_BITS-1:1];
      acc_wdata = mem_wdata;
      acc_be    = mem_byte_enable;
      acc_rd    = mem_read;
      acc_wr    = mem_write;
      acc_bad   = bad_in;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    mem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          count_nx = LAT_M1;
          state_nx = (LAT_M1 != 4'd0) ? BUSY : RESP;
        end
      end
      BUSY: begin
        count_nx = count - 4'd1;
        if (count == 4'd1) state_nx = RESP;
      end
      RESP: begin
        mem_resp = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      mem_rdata <= 16'h0000;
      mem_err   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 16'h0000;
      be_q      <= 2'b00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (state == IDLE && req) begin
        idx_q   <= mem_address[ADDR_BITS-1:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        bad_q   <= bad_in;
      end
      if (enter_resp) begin
        if (acc_bad) begin
          mem_rdata <= 16'h0000;
          mem_err   <= 1'b1;
        end else if (acc_rd) begin
          mem_rdata <= ram[acc_idx];
        end
      end
    end
  end

  // RAM has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_wr && !acc_bad) begin
      if (acc_be[0]) ram[acc_idx][7:0]  <= acc_wdata[7:0];
      if (acc_be[1]) ram[acc_idx][15:8] <= acc_wdata[15:8];
    end
  end

endmodule
